ex_stage_unit: RTL and testbench

Consumer end of the ID/EX pipeline register. It takes the decoded operands and control fields from ID/EX, applies EX/MEM and MEM/WB forwarding, and executes ALU operations. Single-cycle operations finish in one cycle; MUL runs on an iterative multi-cycle engine. Results are held in an integrated EX/MEM output register. While a multi-cycle operation is running, the block drives a stall back to IF/ID/ID-EX.

---
 rtl/ex_stage_unit.sv | 217 +++++++++++++++++++++
 tb/tb_ex_stage_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_unit.sv
// EX stage: operand forwarding, single-cycle ALU and an iterative shift-add multiplier,
// with the EX/MEM output register folded in and a stall back to the front end during MUL.
module ex_stage_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] In_Reg_File_Data1,
    input  logic [DATA_W-1:0] In_Reg_File_Data2,
    input  logic [DATA_W-1:0] In_offset,
    input  logic [4:0]        In_Rs,
    input  logic [4:0]        In_Rt,
    input  logic [4:0]        In_Rd,
    input  logic              In_ALUSrc,
    input  logic              In_MemWrite,
    input  logic              In_MemRead,
    input  logic              In_RegWrite,
    input  logic [3:0]        In_ALUOp,
    input  logic [1:0]        In_MemtoReg,
    input  logic [1:0]        In_RegDst,
    input  logic              Fwd_Mem_RegWrite,
    input  logic [4:0]        Fwd_Mem_Rd,
    input  logic [DATA_W-1:0] Fwd_Mem_Data,
    input  logic              Fwd_Wb_RegWrite,
    input  logic [4:0]        Fwd_Wb_Rd,
    input  logic [DATA_W-1:0] Fwd_Wb_Data,
    output logic [DATA_W-1:0] Out_ALU_Result,
    output logic [DATA_W-1:0] Out_Store_Data,
    output logic [4:0]        Out_Dest_Reg,
    output logic              Out_MemWrite,
    output logic              Out_MemRead,
    output logic              Out_RegWrite,
    output logic [1:0]        Out_MemtoReg,
    output logic              Stall
);

    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam int         CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t r_state, w_state_nxt;
    logic   w_stall;

    logic signed [DATA_W-1:0] w_a, w_rt, w_b;
    logic        [DATA_W-1:0] w_res;
    logic        [4:0]        w_dest;

    logic        [DATA_W-1:0] r_ma, r_mb, r_prod, r_m_store;
    logic        [CNT_W-1:0]  r_cnt;
    logic        [4:0]        r_m_rt, r_m_rd;
    logic        [1:0]        r_m_regdst, r_m_memtoreg;
    logic                     r_m_memwrite, r_m_memread, r_m_regwrite;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [4:0]        rn,
        input logic [DATA_W-1:0] rf_val,
        input logic              mem_we,
        input logic [4:0]        mem_rd,
        input logic [DATA_W-1:0] mem_d,
        input logic              wb_we,
        input logic [4:0]        wb_rd,
        input logic [DATA_W-1:0] wb_d
    );
        if (mem_we && mem_rd != 5'd0 && mem_rd == rn)
            return mem_d;
        else if (wb_we && wb_rd != 5'd0 && wb_rd == rn)
            return wb_d;
        else
            return rf_val;
    endfunction

    function automatic logic [DATA_W-1:0] alu(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic [4:0]               sh
    );
        case (op)
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return ~(a | b);
            4'b0110: return DATA_W'(a < b);
            4'b0111: return DATA_W'($unsigned(a) < $unsigned(b));
            4'b1000: return b << sh;
            4'b1001: return $unsigned(b) >> sh;
            4'b1010: return b >>> sh;
            4'b1011: return b << 16;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [4:0] dest_sel(
        input logic [1:0] regdst,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        case (regdst)
            2'b01:   return rd;
            2'b10:   return 5'd31;
            default: return rt;
        endcase
    endfunction

    always_comb begin
        w_a    = fwd_sel(In_Rs, In_Reg_File_Data1, Fwd_Mem_RegWrite, Fwd_Mem_Rd, Fwd_Mem_Data,
                         Fwd_Wb_RegWrite, Fwd_Wb_Rd, Fwd_Wb_Data);
        w_rt   = fwd_sel(In_Rt, In_Reg_File_Data2, Fwd_Mem_RegWrite, Fwd_Mem_Rd, Fwd_Mem_Data,
                         Fwd_Wb_RegWrite, Fwd_Wb_Rd, Fwd_Wb_Data);
        w_b    = In_ALUSrc ? In_offset : w_rt;
        w_res  = alu(In_ALUOp, w_a, w_b, In_offset[10:6]);
        w_dest = dest_sel(In_RegDst, In_Rt, In_Rd);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (In_ALUOp == OP_MUL) begin
                    w_stall     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == CNT_W'(DATA_W - 1))
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign Stall = w_stall & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_ma           <= '0;
            r_mb           <= '0;
            r_prod         <= '0;
            r_m_store      <= '0;
            r_m_rt         <= '0;
            r_m_rd         <= '0;
            r_m_regdst     <= '0;
            r_m_memtoreg   <= '0;
            r_m_memwrite   <= 1'b0;
            r_m_memread    <= 1'b0;
            r_m_regwrite   <= 1'b0;
            Out_ALU_Result <= '0;
            Out_Store_Data <= '0;
            Out_Dest_Reg   <= '0;
            Out_MemWrite   <= 1'b0;
            Out_MemRead    <= 1'b0;
            Out_RegWrite   <= 1'b0;
            Out_MemtoReg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Bubble by default; only a finished op overwrites it below.
            Out_ALU_Result <= '0;
            Out_Store_Data <= '0;
            Out_Dest_Reg   <= '0;
            Out_MemWrite   <= 1'b0;
            Out_MemRead    <= 1'b0;
            Out_RegWrite   <= 1'b0;
            Out_MemtoReg   <= '0;
            case (r_state)
                IDLE: begin
                    if (In_ALUOp == OP_MUL) begin
                        r_ma         <= w_a;
                        r_mb         <= w_b;
                        r_prod       <= '0;
                        r_cnt        <= '0;
                        r_m_store    <= w_rt;
                        r_m_rt       <= In_Rt;
                        r_m_rd       <= In_Rd;
                        r_m_regdst   <= In_RegDst;
                        r_m_memtoreg <= In_MemtoReg;
                        r_m_memwrite <= In_MemWrite;
                        r_m_memread  <= In_MemRead;
                        r_m_regwrite <= In_RegWrite;
                    end else begin
                        Out_ALU_Result <= w_res;
                        Out_Store_Data <= w_rt;
                        Out_Dest_Reg   <= w_dest;
                        Out_MemWrite   <= In_MemWrite;
                        Out_MemRead    <= In_MemRead;
                        Out_RegWrite   <= In_RegWrite;
                        Out_MemtoReg   <= In_MemtoReg;
                    end
                end
                BUSY: begin
                    if (r_mb[0])
                        r_prod <= r_prod + r_ma;
                    r_ma  <= r_ma << 1;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    Out_ALU_Result <= r_prod;
                    Out_Store_Data <= r_m_store;
                    Out_Dest_Reg   <= dest_sel(r_m_regdst, r_m_rt, r_m_rd);
                    Out_MemWrite   <= r_m_memwrite;
                    Out_MemRead    <= r_m_memread;
                    Out_RegWrite   <= r_m_regwrite;
                    Out_MemtoReg   <= r_m_memtoreg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed bench for ex_stage_unit: a transaction-level model checked every cycle,
// plus literal expectations for the reference cases.
module tb_ex_stage_unit;

    localparam int DATA_W = 32;
    localparam logic [3:0] MUL = 4'hC;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] In_Reg_File_Data1, In_Reg_File_Data2, In_offset;
    logic [4:0]        In_Rs, In_Rt, In_Rd;
    logic              In_ALUSrc, In_MemWrite, In_MemRead, In_RegWrite;
    logic [3:0]        In_ALUOp;
    logic [1:0]        In_MemtoReg, In_RegDst;
    logic              Fwd_Mem_RegWrite, Fwd_Wb_RegWrite;
    logic [4:0]        Fwd_Mem_Rd, Fwd_Wb_Rd;
    logic [DATA_W-1:0] Fwd_Mem_Data, Fwd_Wb_Data;
    logic [DATA_W-1:0] Out_ALU_Result, Out_Store_Data;
    logic [4:0]        Out_Dest_Reg;
    logic              Out_MemWrite, Out_MemRead, Out_RegWrite;
    logic [1:0]        Out_MemtoReg;
    logic              Stall;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ex_stage_unit #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .In_Reg_File_Data1(In_Reg_File_Data1), .In_Reg_File_Data2(In_Reg_File_Data2),
        .In_offset(In_offset), .In_Rs(In_Rs), .In_Rt(In_Rt), .In_Rd(In_Rd),
        .In_ALUSrc(In_ALUSrc), .In_MemWrite(In_MemWrite), .In_MemRead(In_MemRead),
        .In_RegWrite(In_RegWrite), .In_ALUOp(In_ALUOp), .In_MemtoReg(In_MemtoReg),
        .In_RegDst(In_RegDst),
        .Fwd_Mem_RegWrite(Fwd_Mem_RegWrite), .Fwd_Mem_Rd(Fwd_Mem_Rd), .Fwd_Mem_Data(Fwd_Mem_Data),
        .Fwd_Wb_RegWrite(Fwd_Wb_RegWrite), .Fwd_Wb_Rd(Fwd_Wb_Rd), .Fwd_Wb_Data(Fwd_Wb_Data),
        .Out_ALU_Result(Out_ALU_Result), .Out_Store_Data(Out_Store_Data),
        .Out_Dest_Reg(Out_Dest_Reg), .Out_MemWrite(Out_MemWrite), .Out_MemRead(Out_MemRead),
        .Out_RegWrite(Out_RegWrite), .Out_MemtoReg(Out_MemtoReg), .Stall(Stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_fwd(input logic [4:0] rn, input logic [31:0] rf);
        if (Fwd_Mem_RegWrite && Fwd_Mem_Rd != 0 && Fwd_Mem_Rd == rn) return Fwd_Mem_Data;
        if (Fwd_Wb_RegWrite && Fwd_Wb_Rd != 0 && Fwd_Wb_Rd == rn) return Fwd_Wb_Data;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
        case (op)
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return b << sh;
            4'h9: return b >> sh;
            4'hA: return $signed(b) >>> sh;
            4'hB: return {b[15:0], 16'h0000};
            4'hC: return a * b;
            default: return a + b;
        endcase
    endfunction

    logic [31:0] e_alu = 0, e_store = 0, s_alu, s_store;
    logic [4:0]  e_dest = 0, s_dest;
    logic        e_mw = 0, e_mr = 0, e_rw = 0, s_mw, s_mr, s_rw;
    logic [1:0]  e_m2r = 0, s_m2r;
    int          m_cnt = 0;

    always @(posedge clk) begin
        logic [31:0] a, rt, b, r;
        logic [4:0]  d;
        a  = m_fwd(In_Rs, In_Reg_File_Data1);
        rt = m_fwd(In_Rt, In_Reg_File_Data2);
        b  = In_ALUSrc ? In_offset : rt;
        r  = m_alu(In_ALUOp, a, b, int'(In_offset[10:6]));
        d  = (In_RegDst == 2'b01) ? In_Rd : (In_RegDst == 2'b10) ? 5'd31 : In_Rt;
        if (!reset) begin
            m_cnt <= 0;
            {e_alu, e_store, e_dest, e_mw, e_mr, e_rw, e_m2r} <= '0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                e_alu <= s_alu; e_store <= s_store; e_dest <= s_dest;
                e_mw <= s_mw; e_mr <= s_mr; e_rw <= s_rw; e_m2r <= s_m2r;
            end else begin
                {e_alu, e_store, e_dest, e_mw, e_mr, e_rw, e_m2r} <= '0;
            end
        end else if (In_ALUOp == MUL) begin
            s_alu <= r; s_store <= rt; s_dest <= d;
            s_mw <= In_MemWrite; s_mr <= In_MemRead; s_rw <= In_RegWrite; s_m2r <= In_MemtoReg;
            m_cnt <= DATA_W + 1;
            {e_alu, e_store, e_dest, e_mw, e_mr, e_rw, e_m2r} <= '0;
        end else begin
            e_alu <= r; e_store <= rt; e_dest <= d;
            e_mw <= In_MemWrite; e_mr <= In_MemRead; e_rw <= In_RegWrite; e_m2r <= In_MemtoReg;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_alu", Out_ALU_Result, e_alu);
            check("model_store", Out_Store_Data, e_store);
            check("model_dest", {27'd0, Out_Dest_Reg}, {27'd0, e_dest});
            check("model_ctl", {28'd0, Out_MemWrite, Out_MemRead, Out_RegWrite, 1'b0},
                  {28'd0, e_mw, e_mr, e_rw, 1'b0});
            check("model_m2r", {30'd0, Out_MemtoReg}, {30'd0, e_m2r});
            check("model_stall", {31'd0, Stall},
                  {31'd0, reset && ((m_cnt == 0 && In_ALUOp == MUL) || m_cnt >= 2)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] off, input logic src, input logic [1:0] rdst,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        In_ALUOp = op; In_Reg_File_Data1 = d1; In_Reg_File_Data2 = d2; In_offset = off;
        In_ALUSrc = src; In_RegDst = rdst; In_Rs = rs; In_Rt = rt; In_Rd = rd;
        In_RegWrite = 1'b1; In_MemWrite = op[0]; In_MemRead = op[1]; In_MemtoReg = op[3:2];
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
        Fwd_Mem_RegWrite = mwe; Fwd_Mem_Rd = mrd; Fwd_Mem_Data = md;
        Fwd_Wb_RegWrite = wwe; Fwd_Wb_Rd = wrd; Fwd_Wb_Data = wd;
    endtask

    // Waits through the stall window; returns its length, ends in the DONE cycle.
    task automatic run_mul(input int toggle_at, output int n);
        bit ended;
        n = 0;
        ended = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!Stall) begin
                ended = 1'b1;
                break;
            end
            n++;
            if (n > 1) check("mul_bubble_rw", {31'd0, Out_RegWrite}, 32'd0);
            if (n == toggle_at) begin
                In_Reg_File_Data1 = 32'd1000;
                In_Reg_File_Data2 = 32'd77;
                set_fwd(1'b1, In_Rs, 32'd555, 1'b1, In_Rt, 32'd666);
            end
        end
        if (!ended) begin
            n_vec++;
            n_err++;
            $display("FAIL mul_timeout: stall still high after 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    int ns;

    initial begin
        reset = 1'b0;
        issue(4'h0, 0, 0, 0, 1'b0, 2'b00, 0, 0, 0);
        In_RegWrite = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        wait_edge();
        chk_en = 1'b1;
        wait_edge();
        In_ALUOp = MUL;
        #1;
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_alu", Out_ALU_Result, 32'd0);
        check("rst_rw", {31'd0, Out_RegWrite}, 32'd0);

        reset = 1'b1;
        issue(4'h0, 32'd5, 32'd3, 0, 1'b0, 2'b01, 1, 2, 9);
        wait_edge();
        check("add", Out_ALU_Result, 32'd8);
        check("add_dest", {27'd0, Out_Dest_Reg}, 32'd9);
        check("add_rw", {31'd0, Out_RegWrite}, 32'd1);

        set_fwd(1, 4, 32'd100, 1, 4, 32'd200);
        issue(4'h0, 32'd55, 32'd7, 32'd1, 1'b1, 2'b00, 4, 4, 0);
        wait_edge();
        check("fwd_mem", Out_ALU_Result, 32'd101);
        check("fwd_mem_store", Out_Store_Data, 32'd100);
        set_fwd(1, 0, 32'd100, 1, 4, 32'd200);
        wait_edge();
        check("fwd_wb", Out_ALU_Result, 32'd201);
        check("fwd_wb_store", Out_Store_Data, 32'd200);
        set_fwd(1, 0, 32'd100, 1, 0, 32'd200);
        issue(4'h0, 32'd55, 32'd7, 32'd1, 1'b1, 2'b00, 0, 0, 0);
        wait_edge();
        check("fwd_r0", Out_ALU_Result, 32'd56);
        check("fwd_r0_store", Out_Store_Data, 32'd7);
        set_fwd(0, 0, 0, 0, 0, 0);

        issue(4'h6, 32'hFFFF_FFFE, 0, 32'd1, 1'b1, 2'b01, 1, 2, 3);
        wait_edge();
        check("slt", Out_ALU_Result, 32'd1);
        issue(4'h7, 32'hFFFF_FFFE, 0, 32'd1, 1'b1, 2'b01, 1, 2, 3);
        wait_edge();
        check("sltu", Out_ALU_Result, 32'd0);
        issue(4'hA, 0, 32'h8000_0000, 32'h0000_0100, 1'b0, 2'b01, 1, 2, 3);
        wait_edge();
        check("sra", Out_ALU_Result, 32'hF800_0000);
        issue(4'h1, 32'd3, 32'd5, 0, 1'b0, 2'b01, 1, 2, 3);
        wait_edge();
        check("sub_wrap", Out_ALU_Result, 32'hFFFF_FFFE);
        issue(4'hB, 0, 0, 32'h0000_1234, 1'b1, 2'b01, 1, 2, 3);
        wait_edge();
        check("lui", Out_ALU_Result, 32'h1234_0000);
        issue(4'hF, 32'd2, 32'd3, 0, 1'b0, 2'b11, 1, 6, 3);
        wait_edge();
        check("op_f_add", Out_ALU_Result, 32'd5);
        check("rdst11_dest", {27'd0, Out_Dest_Reg}, 32'd6);
        issue(4'h8, 0, 32'h0000_0003, 32'h0000_0080, 1'b0, 2'b00, 1, 2, 3);
        wait_edge();
        check("sll", Out_ALU_Result, 32'd12);

        issue(MUL, 32'd7, 32'd6, 0, 1'b0, 2'b10, 1, 2, 3);
        run_mul(0, ns);
        check("mul_stall_len", ns, 32'd33);
        check("mul_7x6", Out_ALU_Result, 32'd42);
        check("mul_dest", {27'd0, Out_Dest_Reg}, 32'd31);
        check("mul_rw", {31'd0, Out_RegWrite}, 32'd1);

        issue(MUL, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 2'b01, 1, 2, 8);
        run_mul(0, ns);
        check("mul_b2b_stall", ns, 32'd33);
        check("mul_neg", Out_ALU_Result, 32'hFFFF_FFFE);

        issue(MUL, 32'd3, 32'd5, 0, 1'b0, 2'b01, 1, 2, 8);
        run_mul(5, ns);
        check("mul_toggle", Out_ALU_Result, 32'd15);
        set_fwd(0, 0, 0, 0, 0, 0);
        issue(4'h0, 32'd10, 32'd20, 0, 1'b0, 2'b01, 1, 2, 4);
        wait_edge();
        check("add_after_done", Out_ALU_Result, 32'd30);

        issue(MUL, 32'd9, 32'd9, 0, 1'b0, 2'b01, 1, 2, 8);
        repeat (11) wait_edge();
        reset = 1'b0;
        #1;
        check("midmul_rst_stall", {31'd0, Stall}, 32'd0);
        wait_edge();
        check("midmul_rst_alu", Out_ALU_Result, 32'd0);
        check("midmul_rst_dest", {27'd0, Out_Dest_Reg}, 32'd0);
        check("midmul_rst_rw", {31'd0, Out_RegWrite}, 32'd0);
        reset = 1'b1;
        issue(4'h0, 32'd1, 32'd1, 0, 1'b0, 2'b01, 1, 2, 5);
        wait_edge();
        check("post_rst_add", Out_ALU_Result, 32'd2);
        check("post_rst_dest", {27'd0, Out_Dest_Reg}, 32'd5);

        issue(MUL, 32'd9, 32'd9, 0, 1'b0, 2'b01, 1, 2, 8);
        run_mul(0, ns);
        check("mul_9x9", Out_ALU_Result, 32'd81);
        issue(4'h2, 32'hF0F0, 32'hFF00, 0, 1'b0, 2'b01, 1, 2, 3);
        wait_edge();
        check("and", Out_ALU_Result, 32'hF000);
        repeat (2) wait_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
